// File: rtl/vga_timing_pkg.sv
// Shared raster timing constants, counter widths and the sync bundle type
// used by the frame scanner and its sync delay line.
package vga_timing_pkg;

  localparam int CNT_W       = 10;
  localparam int FRAME_CNT_W = 16;
  localparam int MAX_TOTAL   = 1023;

  localparam int DEF_H_VISIBLE  = 640;
  localparam int DEF_H_FRONT    = 16;
  localparam int DEF_H_SYNC     = 96;
  localparam int DEF_H_BACK     = 48;
  localparam int DEF_V_VISIBLE  = 480;
  localparam int DEF_V_FRONT    = 10;
  localparam int DEF_V_SYNC     = 2;
  localparam int DEF_V_BACK     = 33;
  localparam int DEF_SYNC_DELAY = 2;

  typedef struct packed {
    logic blank;
    logic hs;
    logic vs;
  } sync_bus_t;

  function automatic int timing_total(input int visible, input int front,
                                      input int sync, input int back);
    return visible + front + sync + back;
  endfunction

endpackage

// File: rtl/sync_delay_line.sv
// DEPTH-stage shift register that clears to RESET_VALUE on a synchronous
// active-low clear; DEPTH of 0 turns it into a plain wire.
module sync_delay_line #(
  parameter int               DEPTH       = 2,
  parameter int               WIDTH       = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  generate
    if (DEPTH == 0) begin : g_bypass
      logic unused_clk_rst_s;
      assign unused_clk_rst_s = ^{clk_i, rst_n_i};
      assign q_o = d_i;
    end else begin : g_pipe
      logic [WIDTH-1:0] stage_q [DEPTH];

      // Shift stage chain; clear flushes every stage to the idle pattern.
      always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
          for (int i = 0; i < DEPTH; i++) begin
            stage_q[i] <= RESET_VALUE;
          end
        end else begin
          stage_q[0] <= d_i;
          for (int i = 1; i < DEPTH; i++) begin
            stage_q[i] <= stage_q[i-1];
          end
        end
      end

      assign q_o = stage_q[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/vga_frame_scanner.sv
// Raster scan generator: pixel/line counters, registered blank/sync/strobes
// aligned with DrawX/DrawY, delayed sync copies and a frame counter.
module vga_frame_scanner
  import vga_timing_pkg::*;
#(
  parameter int   H_VISIBLE  = DEF_H_VISIBLE,
  parameter int   H_FRONT    = DEF_H_FRONT,
  parameter int   H_SYNC     = DEF_H_SYNC,
  parameter int   H_BACK     = DEF_H_BACK,
  parameter int   V_VISIBLE  = DEF_V_VISIBLE,
  parameter int   V_FRONT    = DEF_V_FRONT,
  parameter int   V_SYNC     = DEF_V_SYNC,
  parameter int   V_BACK     = DEF_V_BACK,
  parameter int   SYNC_DELAY = DEF_SYNC_DELAY,
  parameter logic HS_ACTIVE  = 1'b0,
  parameter logic VS_ACTIVE  = 1'b0
) (
  input  logic                   vga_clk,
  input  logic                   reset_n,
  output logic [CNT_W-1:0]       DrawX,
  output logic [CNT_W-1:0]       DrawY,
  output logic                   blank,
  output logic                   hs,
  output logic                   vs,
  output logic                   blank_d,
  output logic                   hs_d,
  output logic                   vs_d,
  output logic                   line_start,
  output logic                   frame_start,
  output logic [FRAME_CNT_W-1:0] frame_count
);

  localparam int H_TOTAL = timing_total(H_VISIBLE, H_FRONT, H_SYNC, H_BACK);
  localparam int V_TOTAL = timing_total(V_VISIBLE, V_FRONT, V_SYNC, V_BACK);

  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_VIS    = CNT_W'(H_VISIBLE);
  localparam logic [CNT_W-1:0] V_VIS    = CNT_W'(V_VISIBLE);
  localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_VISIBLE + H_FRONT);
  localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_VISIBLE + V_FRONT);
  localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_VISIBLE + V_FRONT + V_SYNC);

  if (H_TOTAL > MAX_TOTAL) begin : g_h_total_chk
    $error("vga_frame_scanner: horizontal total exceeds 10-bit counter range");
  end
  if (V_TOTAL > MAX_TOTAL) begin : g_v_total_chk
    $error("vga_frame_scanner: vertical total exceeds 10-bit counter range");
  end
  if (SYNC_DELAY < 0 || SYNC_DELAY > 7) begin : g_delay_chk
    $error("vga_frame_scanner: SYNC_DELAY must be within 0..7");
  end

  logic [CNT_W-1:0]       hc_q, hc_d, vc_q, vc_d;
  logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic                   vis_q, vis_d, hsync_q, hsync_d, vsync_q, vsync_d;
  logic                   line_start_q, line_start_d, frame_start_q, frame_start_d;
  logic                   h_wrap_s, v_wrap_s;
  sync_bus_t              sync_now_s, sync_dly_s;

  // Next counter values, and the decode of those values so registered flags line up with DrawX/DrawY.
  always_comb begin
    h_wrap_s = (hc_q == H_LAST);
    v_wrap_s = (vc_q == V_LAST);
    if (h_wrap_s) begin
      hc_d = 10'd0;
      if (v_wrap_s) begin
        vc_d = 10'd0;
      end else begin
        vc_d = vc_q + 10'd1;
      end
    end else begin
      hc_d = hc_q + 10'd1;
      vc_d = vc_q;
    end
    frame_cnt_d   = (h_wrap_s && v_wrap_s) ? frame_cnt_q + 16'd1 : frame_cnt_q;
    vis_d         = (hc_d < H_VIS) && (vc_d < V_VIS);
    hsync_d       = (hc_d >= HS_START && hc_d < HS_END) ? HS_ACTIVE : ~HS_ACTIVE;
    vsync_d       = (vc_d >= VS_START && vc_d < VS_END) ? VS_ACTIVE : ~VS_ACTIVE;
    line_start_d  = (hc_d == 10'd0);
    frame_start_d = line_start_d && (vc_d == 10'd0);
  end

  // Counter and flag registers; reset parks the scan at (0,0) with everything idle.
  always_ff @(posedge vga_clk) begin
    if (!reset_n) begin
      hc_q          <= 10'd0;
      vc_q          <= 10'd0;
      frame_cnt_q   <= 16'd0;
      vis_q         <= 1'b0;
      hsync_q       <= ~HS_ACTIVE;
      vsync_q       <= ~VS_ACTIVE;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      hc_q          <= hc_d;
      vc_q          <= vc_d;
      frame_cnt_q   <= frame_cnt_d;
      vis_q         <= vis_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign sync_now_s = {vis_q, hsync_q, vsync_q};

  sync_delay_line #(
    .DEPTH       (SYNC_DELAY),
    .WIDTH       ($bits(sync_bus_t)),
    .RESET_VALUE ({1'b0, ~HS_ACTIVE, ~VS_ACTIVE})
  ) u_sync_delay (
    .clk_i   (vga_clk),
    .rst_n_i (reset_n),
    .d_i     (sync_now_s),
    .q_o     (sync_dly_s)
  );

  assign DrawX       = hc_q;
  assign DrawY       = vc_q;
  assign blank       = vis_q;
  assign hs          = hsync_q;
  assign vs          = vsync_q;
  assign blank_d     = sync_dly_s.blank;
  assign hs_d        = sync_dly_s.hs;
  assign vs_d        = sync_dly_s.vs;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;
  assign frame_count = frame_cnt_q;

endmodule

// File: tb/tb_vga_frame_scanner.sv
// Random-reset bench: three scanners (reduced timing with delay 2 and 0,
// default 640x480 timing) compared each cycle against a time-based model.
module tb_vga_frame_scanner;

  localparam int HV = 16, HF = 2, HSW = 3, HB = 3;
  localparam int VV = 10, VF = 2, VSW = 2, VB = 2;
  localparam int FRAME_A = (HV + HF + HSW + HB) * (VV + VF + VSW + VB);
  localparam bit [2:0] RST3 = 3'b011;

  typedef struct {
    int x, y, fc;
    bit blank, hs, vs, ls, fs;
  } exp_s;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  logic [9:0]  a_x, a_y, b_x, b_y, c_x, c_y;
  logic        a_bl, a_hs, a_vs, a_bd, a_hd, a_vd, a_ls, a_fs;
  logic        b_bl, b_hs, b_vs, b_bd, b_hd, b_vd, b_ls, b_fs;
  logic        c_bl, c_hs, c_vs, c_bd, c_hd, c_vd, c_ls, c_fs;
  logic [15:0] a_fc, b_fc, c_fc;

  vga_frame_scanner #(.H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HSW), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VSW), .V_BACK(VB), .SYNC_DELAY(2)) dut_a (
    .vga_clk(clk), .reset_n(reset_n), .DrawX(a_x), .DrawY(a_y), .blank(a_bl),
    .hs(a_hs), .vs(a_vs), .blank_d(a_bd), .hs_d(a_hd), .vs_d(a_vd),
    .line_start(a_ls), .frame_start(a_fs), .frame_count(a_fc));

  vga_frame_scanner #(.H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HSW), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VSW), .V_BACK(VB), .SYNC_DELAY(0)) dut_b (
    .vga_clk(clk), .reset_n(reset_n), .DrawX(b_x), .DrawY(b_y), .blank(b_bl),
    .hs(b_hs), .vs(b_vs), .blank_d(b_bd), .hs_d(b_hd), .vs_d(b_vd),
    .line_start(b_ls), .frame_start(b_fs), .frame_count(b_fc));

  vga_frame_scanner dut_c (
    .vga_clk(clk), .reset_n(reset_n), .DrawX(c_x), .DrawY(c_y), .blank(c_bl),
    .hs(c_hs), .vs(c_vs), .blank_d(c_bd), .hs_d(c_hd), .vs_d(c_vd),
    .line_start(c_ls), .frame_start(c_fs), .frame_count(c_fc));

  int n_checks = 0;
  int n_fail   = 0;
  int t        = 0;
  int fcb_a    = 0;
  bit [2:0] ha1 = RST3, ha2 = RST3, hc1 = RST3, hc2 = RST3, pa = RST3, pc = RST3;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0d got=%0h expected=%0h", tag, t, got, exp);
    end
  endtask

  // Position is a pure function of cycles since reset release (t); t==0 is the reset state.
  function automatic exp_s ref_model(input int tt, input int fcb, input int hv, input int hf,
                                     input int hsw, input int hb, input int vv, input int vf,
                                     input int vsw, input int vb);
    exp_s e;
    int ht = hv + hf + hsw + hb;
    int vt = vv + vf + vsw + vb;
    e.x     = tt % ht;
    e.y     = (tt / ht) % vt;
    e.fc    = (fcb + tt / (ht * vt)) % 65536;
    e.blank = (tt != 0) && (e.x < hv) && (e.y < vv);
    e.hs    = !((e.x >= hv + hf) && (e.x < hv + hf + hsw));
    e.vs    = !((e.y >= vv + vf) && (e.y < vv + vf + vsw));
    e.ls    = (tt != 0) && (e.x == 0);
    e.fs    = e.ls && (e.y == 0);
    return e;
  endfunction

  task automatic check_inst(input string nm, input exp_s e, input bit [2:0] ed,
                            input logic [9:0] x, input logic [9:0] y, input logic bl,
                            input logic h, input logic v, input logic ls, input logic fs,
                            input logic [15:0] fc, input logic bd, input logic hd, input logic vd);
    check_eq({nm, ".DrawX"},       32'(x),  32'(e.x));
    check_eq({nm, ".DrawY"},       32'(y),  32'(e.y));
    check_eq({nm, ".blank"},       32'(bl), 32'(e.blank));
    check_eq({nm, ".hs"},          32'(h),  32'(e.hs));
    check_eq({nm, ".vs"},          32'(v),  32'(e.vs));
    check_eq({nm, ".line_start"},  32'(ls), 32'(e.ls));
    check_eq({nm, ".frame_start"}, 32'(fs), 32'(e.fs));
    check_eq({nm, ".frame_count"}, 32'(fc), 32'(e.fc));
    check_eq({nm, ".blank_d"},     32'(bd), 32'(ed[2]));
    check_eq({nm, ".hs_d"},        32'(hd), 32'(ed[1]));
    check_eq({nm, ".vs_d"},        32'(vd), 32'(ed[0]));
  endtask

  task automatic step(input bit rst);
    exp_s ea, eb, ec;
    reset_n = ~rst;
    @(posedge clk);
    if (rst) begin
      t = 0; fcb_a = 0;
      ha1 = RST3; ha2 = RST3; hc1 = RST3; hc2 = RST3;
    end else begin
      ha2 = ha1; ha1 = pa; hc2 = hc1; hc1 = pc;
      t++;
    end
    @(negedge clk);
    ea = ref_model(t, fcb_a, HV, HF, HSW, HB, VV, VF, VSW, VB);
    eb = ref_model(t, 0, HV, HF, HSW, HB, VV, VF, VSW, VB);
    ec = ref_model(t, 0, 640, 16, 96, 48, 480, 10, 2, 33);
    pa = {ea.blank, ea.hs, ea.vs};
    pc = {ec.blank, ec.hs, ec.vs};
    check_inst("A", ea, ha2, a_x, a_y, a_bl, a_hs, a_vs, a_ls, a_fs, a_fc, a_bd, a_hd, a_vd);
    check_inst("B", eb, {eb.blank, eb.hs, eb.vs},
               b_x, b_y, b_bl, b_hs, b_vs, b_ls, b_fs, b_fc, b_bd, b_hd, b_vd);
    check_inst("C", ec, hc2, c_x, c_y, c_bl, c_hs, c_vs, c_ls, c_fs, c_fc, c_bd, c_hd, c_vd);
  endtask

  initial begin
    reset_n = 1'b0;
    repeat (5) step(1'b1);
    // Covers one full default line plus more than two reduced frames.
    repeat (900) step(1'b0);
    for (int k = 0; k < 3; k++) begin
      repeat ($urandom_range(40, 700)) step(1'b0);
      repeat ($urandom_range(1, 3)) step(1'b1);
      repeat ($urandom_range(5, 30)) step(1'b0);
    end
    for (int i = 0; i < FRAME_A + 1 && (t % FRAME_A) != 100; i++) step(1'b0);
    force dut_a.frame_cnt_q = 16'hFFFF;
    fcb_a = 65535 - t / FRAME_A;
    step(1'b0);
    release dut_a.frame_cnt_q;
    repeat (FRAME_A + 50) step(1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_frame_scanner.md
Name: vga_frame_scanner

Overview:
- Produces the raster scan that drives every sprite ROM/palette renderer in the Zelda display path.
- Generates DrawX/DrawY, the display-enable `blank`, HS/VS sync, and per-frame/per-line strobes from the pixel clock.
- Sync and enable are also provided delayed, so they line up with renderer colour outputs that arrive a fixed number of cycles after DrawX/DrawY.
- Sits between the pixel clock and the sprite renderers/VGA pins.

Parameters:
- H_VISIBLE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (clocks)
- H_SYNC, 96, horizontal sync width
- H_BACK, 48, horizontal back porch
- V_VISIBLE, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width
- V_BACK, 33, vertical back porch
- SYNC_DELAY, 2, pipeline depth of delayed blank/hs/vs (0..7; 0 = pass-through)
- HS_ACTIVE, 0, level of hs while in sync pulse
- VS_ACTIVE, 0, level of vs while in sync pulse

Ports:
- vga_clk  in  1  pixel clock
- reset_n  in  1  synchronous reset, active low
- DrawX  out  10  current horizontal count (hc)
- DrawY  out  10  current vertical count (vc)
- blank  out  1  1 = (DrawX,DrawY) is visible, aligned with DrawX/DrawY
- hs  out  1  horizontal sync, aligned with DrawX/DrawY
- vs  out  1  vertical sync, aligned with DrawX/DrawY
- blank_d  out  1  blank delayed SYNC_DELAY cycles
- hs_d  out  1  hs delayed SYNC_DELAY cycles
- vs_d  out  1  vs delayed SYNC_DELAY cycles
- line_start  out  1  one-cycle pulse, high when hc==0
- frame_start  out  1  one-cycle pulse, high when hc==0 and vc==0
- frame_count  out  16  completed-frame counter

Behaviour:
- One clock (vga_clk); reset_n is synchronous and active-low.
- Totals: H_TOTAL = H_VISIBLE+H_FRONT+H_SYNC+H_BACK (800); V_TOTAL = V_VISIBLE+V_FRONT+V_SYNC+V_BACK (525).
- hc counts 0..H_TOTAL-1 and wraps to 0. vc increments only on hc wrap and wraps to 0 after V_TOTAL-1.
- DrawX = hc and DrawY = vc, directly from the counter registers.
- blank, hs, vs, line_start and frame_start are registers loaded from the decode of the *next* counter values, so they are aligned with DrawX/DrawY.
  - blank = (hc < H_VISIBLE) && (vc < V_VISIBLE).
  - hs = HS_ACTIVE when H_VISIBLE+H_FRONT <= hc < H_VISIBLE+H_FRONT+H_SYNC (656..751), else ~HS_ACTIVE.
  - vs = VS_ACTIVE when V_VISIBLE+V_FRONT <= vc < V_VISIBLE+V_FRONT+V_SYNC (490..491), else ~VS_ACTIVE.
- Delayed outputs: blank_d/hs_d/vs_d come from a SYNC_DELAY-stage shift register fed by blank/hs/vs. SYNC_DELAY=0 makes them combinational copies.
- frame_count increments by 1 on the (H_TOTAL-1, V_TOTAL-1) -> (0,0) wrap. It wraps 0xFFFF -> 0x0000.
- Reset (any edge with reset_n=0):
  - hc=vc=0, so DrawX=DrawY=0.
  - blank=0; hs=~HS_ACTIVE, vs=~VS_ACTIVE.
  - line_start=0, frame_start=0, frame_count=0.
  - All delay stages cleared to blank=0 / sync inactive.
- First edge after release: hc=1, and decodes become valid.
  - Pixel (0,0) of the first frame is reported blank=0, and no frame_start is issued for the first frame.
  - Normal behaviour applies from the next wrap onward.
- Reset mid-frame: counters restart at (0,0) on that edge. No partial sync pulse is extended; the delay line flushes to inactive values.
- Timing parameters with visible+porches+sync > 1023 are illegal; flag them with an elaboration assertion.

Decomposition:
- vga_timing_pkg:
  - default timing constants
  - H_TOTAL/V_TOTAL derivation function
  - counter width constant (10)
- Sub-module sync_delay_line: parameterized DEPTH × WIDTH shift register with synchronous active-low clear to a RESET_VALUE vector; used once, 3 bits wide.
- Counter/decode logic stays in the top module.

Test Plan:
- Hold reset_n=0 for 5 cycles -> DrawX=DrawY=0, blank=0, hs=vs=1, frame_count=0, blank_d=0, hs_d=vs_d=1.
- Release reset and run one line -> blank high for exactly 639 cycles in line 0 (pixel 0 excluded), then 640 per visible line from line 1; line_start period 800 cycles.
- Run one line -> hs low exactly for DrawX 656..751 (96 cycles); hs_d low 2 cycles later.
- Run 2 full frames -> vs low only on DrawY 490..491 (1600 cycles); frame_start period 420000 cycles; frame_count 0→1→2.
- Reset mid-frame at DrawX=300, DrawY=200 -> next cycle DrawX=0, DrawY=0, frame_count=0, delayed outputs inactive for 2 cycles.
- Force frame_count to 0xFFFF (or run with reduced test timing) then cross a frame wrap -> frame_count=0x0000.
- With SYNC_DELAY=0 -> blank_d/hs_d/vs_d equal blank/hs/vs every cycle.
